// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame length and parity helper.
// Used by both the ps2_kbd_tx transmitter and the ps2_keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StLow,
        StGap
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;

    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO with registered full/empty flags and wrap-bit pointers.
module ps2_tx_fifo #(
    parameter int unsigned Depth = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [7:0]  mem [Depth];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wptr_d  = wptr_q + (AW + 1)'(do_push);
        rptr_d  = rptr_q + (AW + 1)'(do_pop);
        // Same index with opposite wrap bits means every slot is occupied.
        full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
        empty_d = (wptr_d == rptr_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem[rptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queued bytes go out as 11-bit odd-parity frames.
// Optional host-inhibit sensing on ps2_clk_in is enabled with `define PS2TX_INHIBIT_EN.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 30,
    parameter int unsigned IDLE_GAP   = 60,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data
`ifdef PS2TX_INHIBIT_EN
    ,
    input  logic       ps2_clk_in
`endif
);

    localparam int unsigned CNT_MAX = (CLK_DIV > IDLE_GAP) ? CLK_DIV : IDLE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e       state_q, state_d;
    logic [3:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      shift_q, shift_d;
    logic             retx_q, retx_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             ps2_clk_q, ps2_clk_d;
    logic             ps2_data_q, ps2_data_d;

    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             bus_free;
    logic             load;

    ps2_tx_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (clrn),
        .push_i  (wr_en),
        .wdata_i (wr_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef PS2TX_INHIBIT_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ps2_clk_in};
        end
    end

    assign bus_free = sync_q[1];
`else
    assign bus_free = 1'b1;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= StIdle;
            bit_q      <= '0;
            cnt_q      <= '0;
            shift_q    <= '1;
            retx_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            retx_q     <= retx_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        retx_d   = retx_q;
        fifo_pop = 1'b0;
        load     = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = bus_free && (retx_q || !fifo_empty);
            end
            StSetup: begin
                if (!bus_free && (bit_q <= 4'd9)) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    retx_d  = 1'b1;
                end else if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StLow: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = StGap;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = StSetup;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                // Chain straight into the next frame so queued bytes sit exactly IDLE_GAP apart.
                if (cnt_q == CNT_W'(IDLE_GAP - 1)) begin
                    cnt_d = '0;
                    if (bus_free && (retx_q || !fifo_empty)) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d = StSetup;
            bit_d   = '0;
            cnt_d   = '0;
            retx_d  = 1'b0;
            if (!retx_q) begin
                fifo_pop = 1'b1;
                shift_d  = {1'b1, ps2_odd_parity(fifo_rdata), fifo_rdata, 1'b0};
            end
        end
    end

    always_comb begin
        ps2_clk_d  = (state_q != StLow);
        ps2_data_d = 1'b1;
        if ((state_q == StSetup) || (state_q == StLow)) begin
            ps2_data_d = shift_q[bit_q];
        end
        busy_d     = (state_q != StIdle) || !fifo_empty || retx_q;
        overflow_d = overflow_q || (wr_en && fifo_full);
    end

    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx: random byte bursts, frame decoder monitor, timing checks.
module tb_ps2_kbd_tx;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned IDLE_GAP   = 8;
    localparam int unsigned FIFO_DEPTH = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       full, overflow, busy, ps2_clk, ps2_data;

    ps2_kbd_tx #(
        .CLK_DIV    (CLK_DIV),
        .IDLE_GAP   (IDLE_GAP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .overflow (overflow),
        .busy     (busy),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int  occ = 0;
    bit  ovf_exp = 1'b0;
    int  frames_started = 0;
    bit  in_frame = 1'b0;
    int  nbits = 0;
    logic [10:0] bits;
    int  start_t = 0;
    int  end_t = 0;
    bit  gap_pending = 1'b0;
    bit  prev_clk = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Frame as the host sees it, bit 0 first.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (!clrn) begin
            in_frame    = 1'b0;
            nbits       = 0;
            gap_pending = 1'b0;
            prev_clk    = 1'b1;
        end else begin
            if (!in_frame && ps2_clk && !ps2_data) begin
                in_frame = 1'b1;
                nbits    = 0;
                start_t  = cyc;
                frames_started++;
                occ--;
                if (gap_pending) check("gap_len", cyc - end_t, IDLE_GAP);
                gap_pending = 1'b0;
            end else if (in_frame) begin
                if (prev_clk && !ps2_clk) begin
                    if (nbits < 11) bits[nbits] = ps2_data;
                    nbits++;
                end else if (!prev_clk && ps2_clk && nbits == 11) begin
                    in_frame = 1'b0;
                    end_t    = cyc;
                    check("frame_len", cyc - start_t, 22 * CLK_DIV);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {21'd0, bits}, 32'hFFFF_FFFF);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("frame_bits", {21'd0, bits}, {21'd0, ref_frame(e)});
                        gap_pending = (exp_q.size() > 0);
                    end
                end
            end
            prev_clk = ps2_clk;
        end
    end

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        if (occ < int'(FIFO_DEPTH)) begin
            occ++;
            exp_q.push_back(b);
        end else begin
            ovf_exp = 1'b1;
        end
    endtask

    task automatic end_writes();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < 5000), 1);
    endtask

    task automatic wait_start();
        int fs = frames_started;
        int n = 0;
        while (frames_started == fs && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(n < 500), 1);
    endtask

    task automatic burst(input int len);
        for (int i = 0; i < len; i++) drive_byte(8'($urandom_range(0, 255)));
        end_writes();
        check("full_after_burst", 32'(full), 32'(occ == int'(FIFO_DEPTH)));
        check("overflow_sticky", 32'(overflow), 32'(ovf_exp));
    endtask

    initial begin
        int n;
        int fs;
        repeat (3) @(negedge clk);
        check("rst_ps2_clk", 32'(ps2_clk), 1);
        check("rst_ps2_data", 32'(ps2_data), 1);
        check("rst_full", 32'(full), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte: start-bit latency and the 0x1C bit pattern.
        drive_byte(8'h1C);
        @(posedge clk);
        #1 wr_en = 1'b0;
        n = 0;
        while (ps2_data !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("start_latency", n, 2);
        wait_idle();

        // Back-to-back 0x00 / 0xFF: both parity bits 1, exact inter-frame gap.
        drive_byte(8'h00);
        drive_byte(8'hFF);
        end_writes();
        wait_idle();
        check("b2b_drained", exp_q.size(), 0);

        // Ten consecutive writes while a frame is on the wire: eight queue, two drop.
        drive_byte(8'h5A);
        end_writes();
        wait_start();
        for (int i = 0; i < 10; i++) drive_byte(8'(8'h30 + i));
        end_writes();
        check("fill_full", 32'(full), 1);
        check("fill_overflow", 32'(overflow), 1);
        check("fill_model_ovf", 32'(ovf_exp), 1);
        wait_idle();
        check("fill_drained", exp_q.size(), 0);
        check("fill_busy_low", 32'(busy), 0);
        check("fill_full_low", 32'(full), 0);

        // Randomised bursts issued while a frame is in flight.
        for (int it = 0; it < 6; it++) begin
            drive_byte(8'($urandom_range(0, 255)));
            end_writes();
            wait_start();
            repeat ($urandom_range(0, 20)) @(negedge clk);
            burst(int'($urandom_range(1, 10)));
            wait_idle();
            check("rand_drained", exp_q.size(), 0);
        end

        // Reset in the middle of bit 5 with more bytes queued.
        drive_byte(8'hA5);
        end_writes();
        wait_start();
        burst(3);
        n = 0;
        while (nbits < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("bit5_reached", 32'(n < 500), 1);
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check("abort_ps2_clk", 32'(ps2_clk), 1);
        check("abort_ps2_data", 32'(ps2_data), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_full", 32'(full), 0);
        check("abort_overflow", 32'(overflow), 0);
        exp_q.delete();
        occ = 0;
        ovf_exp = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        fs = frames_started;
        repeat (300) @(negedge clk);
        check("no_frames_after_reset", frames_started, fs);
        check("post_reset_data", 32'(ps2_data), 1);
        check("post_reset_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
